// File: rtl/qq_drain_reader.sv
// Dequeue-side reader for quickQueueTop: tracks occupancy from enq pulses, pops one entry
// at a time, captures the result after a fixed latency and streams it out over valid/ready.
module qq_drain_reader #(
    parameter int DATA_W     = 32,
    parameter int DEQ_LAT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        array_size,
    input  logic              drain_en,
    input  logic              enq_mon,
    output logic              deq,
    input  logic [DATA_W-1:0] q_data_lt,
    input  logic [DATA_W-1:0] q_data_rt,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data_lt,
    output logic [DATA_W-1:0] m_data_rt,
    output logic [7:0]        occupancy,
    output logic              q_empty,
    output logic              enq_drop,
    output logic              order_err,
    output logic [1:0]        state_dbg
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (DEQ_LAT > 1) ? $clog2(DEQ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    // Handshake: an entry moves downstream on every cycle where m_valid && m_ready;
    // m_valid never drops and m_data_* never change while the head is waiting for m_ready.

    state_t                state, state_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  push, pop, full;
    logic [2*DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  has_last;
    logic [DATA_W-1:0]     last_key;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (drain_en && occupancy != 8'd0 && fifo_count < CNT_W'(FIFO_DEPTH)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = (DEQ_LAT == 1) ? CAPTURE : WAIT;
            // WAIT lasts DEQ_LAT-1 cycles so the capture edge lands DEQ_LAT cycles after deq.
            WAIT: begin
                if (wait_cnt <= WAIT_W'(1)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        deq       = (state == ISSUE);
        push      = (state == CAPTURE);
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= WAIT_W'(DEQ_LAT - 1);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    assign full    = (occupancy >= array_size);
    assign q_empty = (occupancy == 8'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= 8'd0;
            enq_drop  <= 1'b0;
        end else if (enq_mon && deq) begin
            occupancy <= occupancy;
        end else if (enq_mon) begin
            if (!full) begin
                occupancy <= occupancy + 8'd1;
            end else begin
                enq_drop <= 1'b1;
            end
        end else if (deq) begin
            occupancy <= occupancy - 8'd1;
        end
    end

    // A fresh insert may legally be smaller than the last key, so it restarts the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            order_err <= 1'b0;
            has_last  <= 1'b0;
            last_key  <= '0;
        end else begin
            if (push) begin
                if (has_last && q_data_lt < last_key) begin
                    order_err <= 1'b1;
                end
                last_key <= q_data_lt;
            end
            if (enq_mon) begin
                has_last <= 1'b0;
            end else if (push) begin
                has_last <= 1'b1;
            end
        end
    end

    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid && m_ready;
    assign {m_data_lt, m_data_rt} = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {q_data_lt, q_data_rt};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: doc/qq_drain_reader.md
Name: qq_drain_reader

Overview:
- Dequeue-side reader for quickQueueTop, the counterpart of the enqueue stimulus.
- Tracks queue occupancy by monitoring enq pulses, issues single-cycle deq pulses, and waits a fixed settle latency.
- Captures the queue's data_lt_o/data_rt_o pair into a small output FIFO and streams it downstream over valid/ready.
- Checks that popped keys come out in non-decreasing order (min-priority queue).

Parameters:
- DATA_W, 32: width of each data half (lt/rt).
- DEQ_LAT, 4: cycles from the deq pulse until queue outputs are valid; must be ≥1.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- array_size  in  8  queue capacity; occupancy saturates at this value.
- drain_en  in  1  when high, reader dequeues whenever entries exist.
- enq_mon  in  1  copy of the queue's enq input; one entry is added per high cycle.
- deq  out  1  dequeue pulse to the queue.
- q_data_lt  in  DATA_W  from queue data_lt_o (the key).
- q_data_rt  in  DATA_W  from queue data_rt_o (payload).
- m_valid  out  1  output FIFO not empty.
- m_ready  in  1  downstream accepts the head entry.
- m_data_lt  out  DATA_W  head entry, lt half.
- m_data_rt  out  DATA_W  head entry, rt half.
- occupancy  out  8  entries believed to be in the queue.
- q_empty  out  1  occupancy == 0.
- enq_drop  out  1  sticky; set when enq_mon is seen while occupancy == array_size.
- order_err  out  1  sticky; set when a popped key is smaller than the previous one in the same drain run.

Behaviour:
- Reset (rst low, asynchronous):
  - deq=0, m_valid=0, m_data_lt/m_data_rt=0, occupancy=0, q_empty=1, enq_drop=0, order_err=0.
  - FIFO emptied, FSM to IDLE, has_last=0.
  - Any in-flight dequeue is abandoned.
- Occupancy:
  - enq_mon with occupancy<array_size gives +1.
  - enq_mon at occupancy==array_size gives no change and sets enq_drop.
  - A deq pulse gives -1.
  - enq_mon and deq in the same cycle give a net change of 0; the enq_drop check uses the pre-decrement value only when deq is not also high.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
  - IDLE -> ISSUE when drain_en && occupancy>0 && fifo_count<FIFO_DEPTH. A pop in the same cycle does not affect the check.
  - ISSUE: deq=1 for exactly one cycle; wait counter loaded with DEQ_LAT-1; -> WAIT.
  - WAIT: counter decrements each cycle; at 0 -> CAPTURE.
  - CAPTURE: {q_data_lt, q_data_rt} written into the FIFO; -> IDLE.
- Timing:
  - Decision in cycle T gives deq high in T+1.
  - Capture happens at the edge ending cycle T+1+DEQ_LAT.
  - m_valid is high from T+2+DEQ_LAT if the FIFO was empty.
  - Max throughput: one pop per DEQ_LAT+2 cycles; only one dequeue is outstanding at a time.
- drain_en:
  - Dropping drain_en after ISSUE does not cancel the pop; it completes.
  - It only blocks new issues.
- Output FIFO:
  - Head is shown combinationally on m_data_*.
  - A pop occurs when m_valid && m_ready.
  - A push and pop in the same cycle keep the count.
  - Pointers wrap modulo FIFO_DEPTH.
  - The FIFO never overflows because of the issue gating.
- Order check:
  - On capture, if has_last && q_data_lt < last_key (unsigned), set order_err.
  - Then last_key=q_data_lt and has_last=1.
  - Any enq_mon pulse clears has_last, since a fresh insert may legally be smaller.

Test Plan:
- Reset then drain_en=1 with no enqueues for 10 cycles -> deq never asserted, q_empty=1, m_valid=0.
- array_size=3; enq_mon pulses 5 cycles, drain_en=0 -> occupancy=3, enq_drop=1.
- Keys 4, then 2, enqueued; queue model returns 2 then 4; drain_en=1, m_ready=1, DEQ_LAT=4:
  - deq pulses 6 cycles apart.
  - m_data_lt shows 2 then 4.
  - occupancy ends at 0; order_err=0.
- Model returns 9 then 4 with no intervening enq -> order_err=1 after the second capture and stays set.
- m_ready=0, 6 entries queued (array_size=8), FIFO_DEPTH=4:
  - Exactly 4 deq pulses, then the FSM idles.
  - Raising m_ready drains 4 entries, then the remaining 2 are dequeued.
- rst asserted mid-WAIT -> deq=0, m_valid=0, occupancy=0 immediately (asynchronously); no capture occurs after release.
